// File: rtl/iir_sample_frontend_pkg.sv
// Shared definitions for the IIR sample front end: IEEE-754 single-precision
// field layout and the encoding of the sample-handling FSM states.
package iir_sample_frontend_pkg;

  localparam int SAMPLE_W = 16;
  localparam int FP_W     = 32;
  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int FILL_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONV    = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W-1:0] mantissa;
  } fp32_t;

endpackage

// File: rtl/iir_sample_frontend_convert.sv
// Combinational int16 -> float32 converter. Every 16-bit magnitude fits the
// 24-bit significand, so the result is exact and needs no rounding.
module convert_Z_R
  import iir_sample_frontend_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample_i,
  output fp32_t               fp_o
);

  logic [SAMPLE_W-1:0] mag;
  logic [3:0]          lead;
  logic [MANT_W-1:0]   norm;

  // The 23-bit shift result naturally discards the hidden leading one;
  // -32768 negates to 0x8000 which is still the correct unsigned magnitude.
  always_comb begin
    mag  = sample_i[SAMPLE_W-1] ? (~sample_i + 16'd1) : sample_i;
    lead = '0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (mag[i]) lead = 4'(i);
    end
    norm = {7'd0, mag} << (5'd23 - {1'b0, lead});
    fp_o = '0;
    if (mag != '0) begin
      fp_o.sign     = sample_i[SAMPLE_W-1];
      fp_o.exponent = 8'(EXP_BIAS) + {4'd0, lead};
      fp_o.mantissa = norm;
    end
  end

endmodule

// File: rtl/iir_sample_frontend.sv
// Front end of the IIR datapath: accepts int16 samples, converts them to
// float32 and presents a TAPS-deep window to the filter core over valid/ready.
module iir_sample_frontend
  import iir_sample_frontend_pkg::*;
#(
  parameter int TAPS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SAMPLE_W-1:0]  in_sample,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FP_W*TAPS-1:0] out_x,
  output logic [FILL_W-1:0]    out_fill
);

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] sampleReg_q;
  fp32_t               fpReg_q;
  fp32_t               convOut;
  logic [FP_W-1:0]     taps_q [TAPS];
  logic [FILL_W-1:0]   fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state_q <= ST_IDLE;
    else if (flush) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (in_valid)  state_d = ST_CONV;
      ST_CONV:                   state_d = ST_SHIFT;
      ST_SHIFT:                  state_d = ST_PRESENT;
      ST_PRESENT: if (out_ready) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode registered state only; in_ready is also held low during reset.
  always_comb begin
    in_ready  = rst_n && (state_q == ST_IDLE);
    out_valid = (state_q == ST_PRESENT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         sampleReg_q <= '0;
    else if (!flush && state_q == ST_IDLE && in_valid)  sampleReg_q <= in_sample;
  end

  convert_Z_R u_convert (
    .sample_i (sampleReg_q),
    .fp_o     (convOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  fpReg_q <= '0;
    else if (flush)              fpReg_q <= '0;
    else if (state_q == ST_CONV) fpReg_q <= convOut;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            fill_q <= '0;
    else if (flush)                                        fill_q <= '0;
    else if (state_q == ST_SHIFT && fill_q != FILL_W'(TAPS)) fill_q <= fill_q + 4'd1;
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   taps_q[k] <= '0;
      else if (flush)               taps_q[k] <= '0;
      else if (state_q == ST_SHIFT) taps_q[k] <= (k == 0) ? fpReg_q : taps_q[(k == 0) ? 0 : k-1];
    end
    assign out_x[FP_W*k +: FP_W] = taps_q[k];
  end

  assign out_fill = fill_q;

endmodule

// File: tb/tb_iir_sample_frontend.sv
// Self-checking bench for iir_sample_frontend: random and directed samples
// compared against a queue-based window model using real-number conversion.
module tb_iir_sample_frontend;

  localparam int TAPS = 3;
  localparam int W    = 32 * TAPS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_sample = 16'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_x;
  logic [3:0]   out_fill;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] window [$];

  always #5 clk = ~clk;

  iir_sample_frontend #(.TAPS(TAPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sample (in_sample),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_fill  (out_fill)
  );

  // Reference conversion: go through a double and repack its fields as single precision.
  function automatic logic [31:0] refFloat(input logic signed [15:0] s);
    int v;
    real r;
    logic [63:0] d;
    int e;
    v = s;
    if (v == 0) return 32'h0;
    r = v;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [W-1:0] refWindow();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < TAPS; k++)
      if (k < window.size()) v[32*k +: 32] = window[k];
    return v;
  endfunction

  task automatic modelPush(input logic [15:0] s);
    window.push_front(refFloat(s));
    if (window.size() > TAPS) void'(window.pop_back());
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    window.delete();
  endtask

  task automatic do_sample(input logic [15:0] s, input int hold, input bit preload,
                           input logic [15:0] nextVal);
    int waitCnt;
    logic [W-1:0] expX;
    waitCnt = 0;
    in_sample = s;
    in_valid  = 1'b1;
    while (in_ready !== 1'b1 && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL accept_wait: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    modelPush(s);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL latency_e0: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL latency_e1: out_valid=%b required 0", out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL latency_e2: out_valid=%b required 1", out_valid);
    end
    expX = refWindow();
    vectors++;
    if (out_x !== expX) begin
      miscompares++;
      $display("[TB] FAIL window: sample=%h out_x=%h required %h", s, out_x, expX);
    end
    vectors++;
    if (out_fill !== 4'(window.size())) begin
      miscompares++;
      $display("[TB] FAIL fill: out_fill=%0d required %0d", out_fill, window.size());
    end
    for (int i = 0; i < hold; i++) begin
      if (preload) begin
        in_valid  = 1'b1;
        in_sample = nextVal;
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_x !== expX) begin
        miscompares++;
        $display("[TB] FAIL hold: out_valid=%b in_ready=%b out_x=%h required 1 0 %h",
                 out_valid, in_ready, out_x, expX);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hs: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
    end
    vectors++;
    if (out_x !== '0 || out_fill !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: out_x=%h out_fill=%0d required 0 0", out_x, out_fill);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    do_sample(16'hFFFF, 0, 1'b0, 16'h0);
    vectors++;
    if (out_x[31:0] !== 32'hBF800000 || out_fill !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL minus_one: x0=%h fill=%0d required bf800000 1", out_x[31:0], out_fill);
    end
    do_flush();
    do_sample(16'd1, 0, 1'b0, 16'h0);
    do_sample(16'd2, 0, 1'b0, 16'h0);
    do_sample(16'd3, 0, 1'b0, 16'h0);
    vectors++;
    if (out_x !== {32'h3F800000, 32'h40000000, 32'h40400000} || out_fill !== 4'd3) begin
      miscompares++;
      $display("[TB] FAIL one_two_three: out_x=%h fill=%0d", out_x, out_fill);
    end
    do_sample(16'h0000, 0, 1'b0, 16'h0);
    vectors++;
    if (out_x[31:0] !== 32'h00000000) begin
      miscompares++;
      $display("[TB] FAIL zero: x0=%h required 00000000", out_x[31:0]);
    end
    do_sample(16'h8000, 0, 1'b0, 16'h0);
    vectors++;
    if (out_x[31:0] !== 32'hC7000000) begin
      miscompares++;
      $display("[TB] FAIL most_negative: x0=%h required c7000000", out_x[31:0]);
    end
    do_sample(16'h7FFF, 0, 1'b0, 16'h0);
    vectors++;
    if (out_x[31:0] !== 32'h46FFFE00) begin
      miscompares++;
      $display("[TB] FAIL most_positive: x0=%h required 46fffe00", out_x[31:0]);
    end
  endtask

  task automatic test_backpressure();
    do_sample(16'h1234, 5, 1'b1, 16'hABCD);
    do_sample(16'hABCD, 2, 1'b0, 16'h0);
  endtask

  task automatic test_flush();
    do_flush();
    do_sample(16'd100, 0, 1'b0, 16'h0);
    in_sample = 16'hFF00;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_setup: out_valid=%b required 1", out_valid);
    end
    do_flush();
    vectors++;
    if (out_valid !== 1'b0 || out_x !== '0 || out_fill !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL flush_present: out_valid=%b out_x=%h fill=%0d required 0 0 0",
               out_valid, out_x, out_fill);
    end
    in_sample = 16'h0042;
    in_valid  = 1'b1;
    do_flush();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_idle: in_ready=%b required 1", in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_fill !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL flush_idle_taken: out_valid=%b fill=%0d required 0 0", out_valid, out_fill);
    end
    do_sample(16'hFFF6, 0, 1'b0, 16'h0);
    vectors++;
    if (out_fill !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL flush_refill: out_fill=%0d required 1", out_fill);
    end
  endtask

  task automatic test_reset_mid();
    do_sample(16'd5, 0, 1'b0, 16'h0);
    in_sample = 16'd9;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_x !== '0 || out_fill !== 4'd0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: out_valid=%b out_x=%h fill=%0d in_ready=%b required 0 0 0 0",
               out_valid, out_x, out_fill, in_ready);
    end
    window.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    do_sample(16'd7, 0, 1'b0, 16'h0);
  endtask

  task automatic test_random();
    logic [15:0] s;
    for (int n = 0; n < 30; n++) begin
      s = 16'($urandom);
      do_sample(s, $urandom_range(0, 3), 1'b0, 16'h0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
